// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - control-bit indices, opcodes, state encoding and helpers for the accumulator CPU sequencer
package cpu_ctrl_pkg;

    // Control word bit indices
    localparam int C0  = 0;   // PC -> MAR
    localparam int C1  = 1;   // memory read -> MBR
    localparam int C2  = 2;   // PC + 1
    localparam int C3  = 3;   // MBR -> IR
    localparam int C4  = 4;   // IR.addr -> MAR
    localparam int C5  = 5;   // MBR -> BR
    localparam int C6  = 6;   // ACC -> MBR
    localparam int C7  = 7;   // MBR -> memory write
    localparam int C8  = 8;   // ACC clear
    localparam int C9  = 9;   // ALU add
    localparam int C10 = 10;  // ALU -> ACC latch
    localparam int C11 = 11;  // ALU sub
    localparam int C12 = 12;  // ALU mul
    localparam int C13 = 13;  // IR.addr -> PC
    localparam int C14 = 14;  // ALU and
    localparam int C15 = 15;  // ALU or
    localparam int C16 = 16;  // ALU not
    localparam int C17 = 17;  // ALU shr
    localparam int C18 = 18;  // ALU shl
    localparam int C19 = 19;  // ALU high half -> OFR latch
    localparam int C20 = 20;  // halt

    // ALU operation bits, shared with the ALU
    localparam int ALU_ADD = 9;
    localparam int ALU_SUB = 11;
    localparam int ALU_MUL = 12;
    localparam int ALU_AND = 14;
    localparam int ALU_OR  = 15;
    localparam int ALU_NOT = 16;
    localparam int ALU_SHR = 17;
    localparam int ALU_SHL = 18;

    // Opcodes
    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_STORE  = 8'h01;
    localparam logic [7:0] OP_LOAD   = 8'h02;
    localparam logic [7:0] OP_ADD    = 8'h03;
    localparam logic [7:0] OP_SUB    = 8'h04;
    localparam logic [7:0] OP_JMPGEZ = 8'h05;
    localparam logic [7:0] OP_JMP    = 8'h06;
    localparam logic [7:0] OP_HALT   = 8'h07;
    localparam logic [7:0] OP_MPY    = 8'h08;
    localparam logic [7:0] OP_AND    = 8'h0A;
    localparam logic [7:0] OP_OR     = 8'h0B;
    localparam logic [7:0] OP_NOT    = 8'h0C;
    localparam logic [7:0] OP_SHR    = 8'h0D;
    localparam logic [7:0] OP_SHL    = 8'h0E;

    typedef enum logic [2:0] {
        ST_IDLE, ST_F0, ST_F1, ST_F2, ST_DECODE, ST_EXEC, ST_HALTED
    } state_t;

    // Execute-sequence families; every opcode maps onto exactly one
    typedef enum logic [2:0] {
        K_NOP, K_MEM_ALU, K_LOAD, K_STORE, K_JMP, K_JMPGEZ, K_UNARY, K_HALT
    } op_kind_t;

    function automatic op_kind_t op_kind(input logic [7:0] op);
        case (op)
            OP_STORE:                                 return K_STORE;
            OP_LOAD:                                  return K_LOAD;
            OP_ADD, OP_SUB, OP_MPY, OP_AND, OP_OR:    return K_MEM_ALU;
            OP_JMPGEZ:                                return K_JMPGEZ;
            OP_JMP:                                   return K_JMP;
            OP_HALT:                                  return K_HALT;
            OP_NOT, OP_SHR, OP_SHL:                   return K_UNARY;
            default:                                  return K_NOP;
        endcase
    endfunction

    // Bit index of the ALU operation for an arithmetic/logic opcode
    function automatic logic [4:0] alu_bit(input logic [7:0] op);
        case (op)
            OP_SUB:  return 5'(ALU_SUB);
            OP_MPY:  return 5'(ALU_MUL);
            OP_AND:  return 5'(ALU_AND);
            OP_OR:   return 5'(ALU_OR);
            OP_NOT:  return 5'(ALU_NOT);
            OP_SHR:  return 5'(ALU_SHR);
            OP_SHL:  return 5'(ALU_SHL);
            default: return 5'(ALU_ADD);
        endcase
    endfunction

    function automatic logic [2:0] last_step(input op_kind_t k);
        case (k)
            K_LOAD:    return 3'd4;
            K_MEM_ALU: return 3'd3;
            K_STORE:   return 3'd2;
            default:   return 3'd0;
        endcase
    endfunction

    // Execute steps that wait on the memory handshake
    function automatic logic stall_step(input op_kind_t k, input logic [2:0] step);
        return ((k == K_LOAD || k == K_MEM_ALU) && step == 3'd1) ||
               (k == K_STORE && step == 3'd2);
    endfunction

    function automatic logic [3:0] fsm_code(input state_t s, input logic [2:0] step);
        case (s)
            ST_F0:     return 4'd1;
            ST_F1:     return 4'd2;
            ST_F2:     return 4'd3;
            ST_DECODE: return 4'd4;
            ST_EXEC:   return 4'd5 + {1'b0, step};
            ST_HALTED: return 4'd15;
            default:   return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// rtl/micro_sequencer_if.sv - sequencer <-> datapath control/status bundle
// master: the sequencer (drives control_signal, halted, fsm_state)
// slave:  the datapath/memory side (drives ir_opcode, acc_sign, mem_ready)
interface micro_sequencer_if #(
    parameter int OPCODE_W = 8,
    parameter int CTRL_W   = 32
) ();
    logic [OPCODE_W-1:0] ir_opcode;
    logic                acc_sign;
    logic                mem_ready;
    logic [CTRL_W-1:0]   control_signal;
    logic                halted;
    logic [3:0]          fsm_state;

    modport master (
        input  ir_opcode, acc_sign, mem_ready,
        output control_signal, halted, fsm_state
    );

    modport slave (
        output ir_opcode, acc_sign, mem_ready,
        input  control_signal, halted, fsm_state
    );
endinterface

// File: rtl/micro_decode.sv
// rtl/micro_decode.sv - combinational (state, step, opcode, acc_sign) -> control word
// Ports: state_i/step_i/opcode_i/acc_sign_i in, ctrl_o out (CTRL_W bits, 21..31 always 0)
module micro_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 8,
    parameter int CTRL_W   = 32
) (
    input  state_t              state_i,
    input  logic [2:0]          step_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                acc_sign_i,
    output logic [CTRL_W-1:0]   ctrl_o
);
    logic [7:0] op8;
    op_kind_t   kind;

    // Only the low 8 opcode bits select an instruction
    assign op8  = opcode_i[7:0];
    assign kind = op_kind(op8);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_F0: ctrl_o[C0] = 1'b1;
            ST_F1: ctrl_o[C1] = 1'b1;
            ST_F2: begin
                ctrl_o[C2] = 1'b1;
                ctrl_o[C3] = 1'b1;
            end
            ST_EXEC: begin
                case (kind)
                    K_LOAD, K_MEM_ALU: begin
                        case (step_i)
                            3'd0: ctrl_o[C4] = 1'b1;
                            3'd1: ctrl_o[C1] = 1'b1;
                            3'd2: ctrl_o[C5] = 1'b1;
                            3'd3: begin
                                if (kind == K_LOAD) begin
                                    ctrl_o[C8] = 1'b1;
                                end else begin
                                    ctrl_o[alu_bit(op8)] = 1'b1;
                                    ctrl_o[C10] = 1'b1;
                                    ctrl_o[C19] = 1'b1;
                                end
                            end
                            3'd4: begin
                                // LOAD finishes as ACC = 0 + BR
                                ctrl_o[C9]  = 1'b1;
                                ctrl_o[C10] = 1'b1;
                            end
                            default: ctrl_o = '0;
                        endcase
                    end
                    K_STORE: begin
                        case (step_i)
                            3'd0:    ctrl_o[C4] = 1'b1;
                            3'd1:    ctrl_o[C6] = 1'b1;
                            3'd2:    ctrl_o[C7] = 1'b1;
                            default: ctrl_o = '0;
                        endcase
                    end
                    K_JMP:    ctrl_o[C13] = 1'b1;
                    K_JMPGEZ: ctrl_o[C13] = ~acc_sign_i;
                    K_UNARY: begin
                        ctrl_o[alu_bit(op8)] = 1'b1;
                        ctrl_o[C10] = 1'b1;
                    end
                    default: ctrl_o = '0;
                endcase
            end
            ST_HALTED: ctrl_o[C20] = 1'b1;
            default:   ctrl_o = '0;
        endcase
    end
endmodule

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - fetch/decode/execute control FSM of the accumulator CPU
// Ports: clk, rst (sync, active-high); bus (master): ir_opcode, acc_sign, mem_ready in;
//        control_signal, halted, fsm_state out (all registered)
module micro_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 8,
    parameter int CTRL_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    micro_sequencer_if.master  bus
);
    state_t              state_q, state_d;
    logic [2:0]          step_q, step_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic                halted_q;
    logic [3:0]          fsm_q;
    op_kind_t            kind_q, kind_in;

    assign kind_q  = op_kind(opcode_q[7:0]);
    assign kind_in = op_kind(bus.ir_opcode[7:0]);

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        opcode_d = opcode_q;
        case (state_q)
            ST_IDLE: state_d = ST_F0;
            ST_F0:   state_d = ST_F1;
            ST_F1:   if (bus.mem_ready) state_d = ST_F2;
            ST_F2:   state_d = ST_DECODE;
            ST_DECODE: begin
                opcode_d = bus.ir_opcode;
                step_d   = 3'd0;
                case (kind_in)
                    K_HALT:  state_d = ST_HALTED;
                    K_NOP:   state_d = ST_F0;
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                if (stall_step(kind_q, step_q) && !bus.mem_ready) begin
                    state_d = ST_EXEC;
                end else if (step_q == last_step(kind_q)) begin
                    state_d = ST_F0;
                    step_d  = 3'd0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output word is decoded from the state being entered, so it is
    // visible for exactly the cycles the FSM occupies that state.
    micro_decode #(
        .OPCODE_W (OPCODE_W),
        .CTRL_W   (CTRL_W)
    ) u_decode (
        .state_i    (state_d),
        .step_i     (step_d),
        .opcode_i   (opcode_d),
        .acc_sign_i (bus.acc_sign),
        .ctrl_o     (ctrl_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            step_q   <= 3'd0;
            opcode_q <= '0;
            ctrl_q   <= '0;
            halted_q <= 1'b0;
            fsm_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            opcode_q <= opcode_d;
            ctrl_q   <= ctrl_d;
            halted_q <= (state_d == ST_HALTED);
            fsm_q    <= fsm_code(state_d, step_d);
        end
    end

    assign bus.control_signal = ctrl_q;
    assign bus.halted         = halted_q;
    assign bus.fsm_state      = fsm_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - scoreboard bench for micro_sequencer
module tb_micro_sequencer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    micro_sequencer_if #(.OPCODE_W(8), .CTRL_W(32)) bus ();

    micro_sequencer #(.OPCODE_W(8), .CTRL_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        string       tag;
        logic [31:0] w;
        logic [3:0]  st;
        logic        h;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Expectation for the outputs after the coming rising edge
    task automatic cyc(input string tag, input logic [31:0] w, input logic [3:0] st, input logic h);
        exp_t e;
        e.tag = tag;
        e.w   = w;
        e.st  = st;
        e.h   = h;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic fetch(input string tag);
        cyc({tag, "_f1"}, 32'h2, 4'd2, 1'b0);
        cyc({tag, "_f2"}, 32'hC, 4'd3, 1'b0);
        cyc({tag, "_dec"}, 32'h0, 4'd4, 1'b0);
    endtask

    exp_t m;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            m = exp_q.pop_front();
            checks++;
            if (bus.control_signal !== m.w || bus.fsm_state !== m.st || bus.halted !== m.h) begin
                failures++;
                $display("FAIL %s: got word=%h state=%0d halted=%b, expected word=%h state=%0d halted=%b",
                         m.tag, bus.control_signal, bus.fsm_state, bus.halted, m.w, m.st, m.h);
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        bus.acc_sign  = 1'b0;
        bus.ir_opcode = 8'h03;

        cyc("reset0", 32'h0, 4'd0, 1'b0);
        cyc("reset1", 32'h0, 4'd0, 1'b0);
        rst = 1'b0;

        // ADD, no stalls
        cyc("add_f0", 32'h1, 4'd1, 1'b0);
        fetch("add");
        cyc("add_e0", 32'h10, 4'd5, 1'b0);
        cyc("add_e1", 32'h2, 4'd6, 1'b0);
        cyc("add_e2", 32'h20, 4'd7, 1'b0);
        cyc("add_e3", 32'h00080600, 4'd8, 1'b0);
        cyc("add_next_f0", 32'h1, 4'd1, 1'b0);

        // LOAD with a 3-cycle stall in E1
        bus.ir_opcode = 8'h02;
        fetch("load");
        cyc("load_e0", 32'h10, 4'd5, 1'b0);
        cyc("load_e1", 32'h2, 4'd6, 1'b0);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("load_e1_stall", 32'h2, 4'd6, 1'b0);
        bus.mem_ready = 1'b1;
        cyc("load_e2", 32'h20, 4'd7, 1'b0);
        cyc("load_e3", 32'h100, 4'd8, 1'b0);
        cyc("load_e4", 32'h600, 4'd9, 1'b0);
        cyc("load_next_f0", 32'h1, 4'd1, 1'b0);

        // JMPGEZ taken and not taken
        bus.ir_opcode = 8'h05;
        fetch("jgez0");
        cyc("jgez0_e0", 32'h2000, 4'd5, 1'b0);
        cyc("jgez0_f0", 32'h1, 4'd1, 1'b0);
        bus.acc_sign = 1'b1;
        fetch("jgez1");
        cyc("jgez1_e0", 32'h0, 4'd5, 1'b0);
        cyc("jgez1_f0", 32'h1, 4'd1, 1'b0);
        bus.acc_sign = 1'b0;

        // NOT, single execute step
        bus.ir_opcode = 8'h0C;
        fetch("not");
        cyc("not_e0", 32'h00010400, 4'd5, 1'b0);
        cyc("not_f0", 32'h1, 4'd1, 1'b0);

        // Unknown opcode behaves as NOP
        bus.ir_opcode = 8'hFF;
        fetch("unk");
        cyc("unk_f0", 32'h1, 4'd1, 1'b0);

        // STORE, reset during the E2 stall
        bus.ir_opcode = 8'h01;
        fetch("store");
        cyc("store_e0", 32'h10, 4'd5, 1'b0);
        cyc("store_e1", 32'h40, 4'd6, 1'b0);
        cyc("store_e2", 32'h80, 4'd7, 1'b0);
        bus.mem_ready = 1'b0;
        cyc("store_e2_stall", 32'h80, 4'd7, 1'b0);
        rst = 1'b1;
        cyc("store_rst", 32'h0, 4'd0, 1'b0);
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        cyc("store_rst_f0", 32'h1, 4'd1, 1'b0);

        // HALT holds until reset, mem_ready irrelevant
        bus.ir_opcode = 8'h07;
        fetch("halt");
        for (int i = 0; i < 20; i++) begin
            bus.mem_ready = i[0];
            cyc("halted", 32'h00100000, 4'd15, 1'b1);
        end
        bus.mem_ready = 1'b1;
        rst = 1'b1;
        cyc("halt_rst", 32'h0, 4'd0, 1'b0);
        rst = 1'b0;
        cyc("halt_rst_f0", 32'h1, 4'd1, 1'b0);

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
